// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the RV32I immediate encoder
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4095;
  localparam int signed IMM21_MIN = -(1 << 20);
  localparam int signed IMM21_MAX = (1 << 20) - 1;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  function automatic logic fits_signed(input logic [31:0] v, input int signed lo,
                                       input int signed hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// rtl/imm_field_pack.sv - combinational packing of an immediate into an RV32I word
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  input  logic [31:0] base_inst,
  output logic [31:0] inst,
  output logic        range_err
);

  // Illegal selectors fall through with base_inst untouched and the error set.
  always_comb begin
    inst      = base_inst;
    range_err = 1'b1;
    case (imm_src)
      IMM_I: begin
        inst[31:20] = imm[11:0];
        range_err   = !fits_signed(imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        range_err   = !fits_signed(imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_B: begin
        inst[31]    = imm[12];
        inst[7]     = imm[11];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        range_err   = !fits_signed(imm, IMM13_MIN, IMM13_MAX) || imm[0];
      end
      IMM_J: begin
        inst[31]    = imm[20];
        inst[19:12] = imm[19:12];
        inst[20]    = imm[11];
        inst[30:21] = imm[10:1];
        range_err   = !fits_signed(imm, IMM21_MIN, IMM21_MAX) || imm[0];
      end
      IMM_U: begin
        inst[31:12] = imm[31:12];
        range_err   = (imm[11:0] != 12'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - 2-stage immediate encoder pipeline with statistics
// Optional IMM_ENC_ADDR_GEN_EN adds the out_addr word-address output.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             range_err,
  output logic [CNT_W-1:0] enc_count,
`ifdef IMM_ENC_ADDR_GEN_EN
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      out_addr
`else
  output logic [CNT_W-1:0] err_count
`endif
);

  logic             a_valid_q, b_valid_q;
  logic [31:0]      a_imm_q, a_base_q;
  logic [2:0]       a_src_q;
  logic [31:0]      a_inst, b_inst_q;
  logic             a_err, b_err_q;
  logic             a_adv, b_adv, out_hs;
  logic [CNT_W-1:0] enc_q, enc_d, err_q, err_d;

  assign b_adv    = !b_valid_q || out_ready;
  assign a_adv    = !a_valid_q || b_adv;
  assign in_ready = a_adv;
  assign out_hs   = b_valid_q && out_ready;

  imm_field_pack u_pack (
    .imm       (a_imm_q),
    .imm_src   (a_src_q),
    .base_inst (a_base_q),
    .inst      (a_inst),
    .range_err (a_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_imm_q   <= '0;
      a_src_q   <= '0;
      a_base_q  <= '0;
    end else if (a_adv) begin
      a_valid_q <= in_valid;
      if (in_valid) begin
        a_imm_q  <= imm;
        a_src_q  <= imm_src;
        a_base_q <= base_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      b_inst_q  <= '0;
      b_err_q   <= 1'b0;
    end else if (b_adv) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_inst_q <= a_inst;
        b_err_q  <= a_err;
      end
    end
  end

  // Saturating counters: each holds at all-ones independently of the other.
  always_comb begin
    enc_d = enc_q;
    err_d = err_q;
    if (out_hs && (enc_q != '1)) enc_d = enc_q + 1'b1;
    if (out_hs && b_err_q && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q <= '0;
      err_q <= '0;
    end else begin
      enc_q <= enc_d;
      err_q <= err_d;
    end
  end

`ifdef IMM_ENC_ADDR_GEN_EN
  logic [31:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= START_ADDR;
    end else if (out_hs) begin
      addr_q <= addr_q + 32'd4;
    end
  end

  assign out_addr = addr_q;
`else
  logic unused_start_addr;
  assign unused_start_addr = ^START_ADDR;
`endif

  assign out_valid = b_valid_q;
  assign inst      = b_inst_q;
  assign range_err = b_err_q;
  assign enc_count = enc_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder (CNT_W=4)
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int          CNT_W = 4;
  localparam logic [31:0] START = 32'h0000_1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       imm_src = '0;
  logic [31:0]      imm = '0;
  logic [31:0]      base_inst = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      inst;
  logic             range_err;
  logic [CNT_W-1:0] enc_count, err_count;
`ifdef IMM_ENC_ADDR_GEN_EN
  logic [31:0]      out_addr;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [32:0]      sb[$];
  logic [CNT_W-1:0] m_enc = '0;
  logic [CNT_W-1:0] m_err = '0;
  logic [31:0]      m_addr = START;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(CNT_W), .START_ADDR(START)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_src   (imm_src),
    .imm       (imm),
    .base_inst (base_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .range_err (range_err),
    .enc_count (enc_count),
`ifdef IMM_ENC_ADDR_GEN_EN
    .err_count (err_count),
    .out_addr  (out_addr)
`else
    .err_count (err_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding written from the field tables; returns {range_err, inst}.
  function automatic logic [32:0] model(input logic [2:0] src, input logic [31:0] v,
                                        input logic [31:0] b);
    int signed s;
    s = $signed(v);
    case (src)
      3'd0: return {(s < -2048 || s > 2047), v[11:0], b[19:0]};
      3'd1: return {(s < -2048 || s > 2047), v[11:5], b[24:12], v[4:0], b[6:0]};
      3'd2: return {(s < -4096 || s > 4095 || v[0]), v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
      3'd3: return {(s < -1048576 || s > 1048575 || v[0]), v[20], v[10:1], v[11], v[19:12], b[11:0]};
      3'd4: return {(v[11:0] != 12'd0), v[31:12], b[11:0]};
      default: return {1'b1, b};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [32:0] e;
        check("enc_count", enc_count, m_enc);
        check("err_count", err_count, m_err);
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("inst", inst, e[31:0]);
          check("range_err", range_err, e[32]);
`ifdef IMM_ENC_ADDR_GEN_EN
          check("out_addr", out_addr, m_addr);
`endif
          if (m_enc != '1) m_enc = m_enc + 1'b1;
          if (e[32] && m_err != '1) m_err = m_err + 1'b1;
          m_addr = m_addr + 32'd4;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(imm_src, imm, base_inst));
    end
  end

  task automatic set_req(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
    imm_src = s; imm = v; base_inst = b; in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
    @(posedge clk); #1;
    set_req(s, v, b);
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string tag, input logic [31:0] exp_inst);
    drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
    @(negedge clk);
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_lat2_inst"}, inst, exp_inst);
    check({tag, "_lat2_err"}, range_err, 0);
    @(negedge clk);
    check({tag, "_enc_after"}, enc_count, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] w0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_range_err", range_err, 0);
    check("rst_enc", enc_count, 0);
    check("rst_err", err_count, 0);
`ifdef IMM_ENC_ADDR_GEN_EN
    check("rst_addr", out_addr, START);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    latency_check("first", 32'hFFF0_0013);

    drive(3'd1, 32'd8, 32'h0000_2023);
    drive(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    drive(3'd3, 32'h0000_0800, 32'h0000_006F);
    drive(3'd4, 32'h1234_5001, 32'h0000_0037);
    drive(3'd0, 32'd2048, 32'h0000_0013);
    drive(3'd2, 32'd6, 32'h0000_0063);
    drive(3'd2, 32'd5, 32'h0000_0063);
    drive(3'd7, 32'h0000_0123, 32'hDEAD_BEEF);
    idle(4);
    check("dir_S", model(3'd1, 32'd8, 32'h2023), {1'b0, 32'h0000_2423});
    check("enc_after_dir", enc_count, 9);
    check("err_after_dir", err_count, 4);

    // Backpressure: third request must stall while the two-deep pipe is full.
    out_ready = 1'b0;
    @(posedge clk); #1;
    set_req(3'd0, 32'd100, 32'h0000_0013);
    w0 = model(3'd0, 32'd100, 32'h0000_0013);
    @(negedge clk); check("bp_ready0", in_ready, 1);
    @(posedge clk); #1;
    set_req(3'd1, 32'hFFFF_FFF0, 32'h0000_2023);
    @(negedge clk); check("bp_ready1", in_ready, 1);
    @(posedge clk); #1;
    set_req(3'd3, 32'h0000_0010, 32'h0000_00EF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_inst", inst, w0[31:0]);
    end
    check("bp_sb_depth", sb.size(), 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    idle(5);
    check("bp_drained", sb.size(), 0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    @(posedge clk); #1;
    set_req(3'd0, 32'd1, 32'h0000_0013);
    @(posedge clk); #1;
    set_req(3'd0, 32'd2, 32'h0000_0013);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_enc", enc_count, 0);
    check("mid_rst_err", err_count, 0);
    sb.delete();
    m_enc = '0;
    m_err = '0;
    m_addr = START;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    latency_check("post_rst", 32'hFFF0_0013);

    // Streaming with random requests; counters must saturate at 15.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0)
        set_req(3'($urandom_range(0, 7)), $urandom, $urandom);
      else
        set_req(3'($urandom_range(0, 4)), 32'($urandom_range(0, 1024)) << 1, $urandom);
      wait_accept();
    end
    in_valid = 1'b0;
    idle(5);
    check("sat_enc", enc_count, 15);
    check("sat_err_model", err_count, m_err);
    check("sat_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
